// File: rtl/route_pkg.sv
// ---------------------------------------------------------------------------
// route_pkg
// Shared definitions for the route grant sequencer: route count, route index
// width, the pairwise route conflict matrix, the sequencer FSM state type and
// small helpers for round-robin candidate selection and one-hot decode.
// ---------------------------------------------------------------------------
package route_pkg;

    localparam int NUM_ROUTES  = 8;
    localparam int ROUTE_IDX_W = 3;

    typedef logic [NUM_ROUTES-1:0]  route_mask_t;
    typedef logic [ROUTE_IDX_W-1:0] route_idx_t;

    // Row i lists the routes that conflict with route i: i+1, i-1 and i+4
    // (mod 8). The matrix is symmetric and has an empty diagonal.
    // Row 0 sits in the least-significant byte.
    localparam logic [NUM_ROUTES-1:0][NUM_ROUTES-1:0] ROUTE_CONFLICT =
        64'h49A4_5229_944A_2592;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_LOCK  = 2'd2
    } seq_state_t;

    typedef struct packed {
        logic       found;
        route_idx_t idx;
    } route_pick_t;

    // Lowest index at or after ptr (wrapping) whose mask bit is set.
    // Scanning from the far end lets the closest hit overwrite later ones.
    function automatic route_pick_t rr_pick(input route_mask_t mask,
                                            input route_idx_t  ptr);
        route_pick_t pick;
        route_idx_t  idx;
        pick = '0;
        for (int k = NUM_ROUTES - 1; k >= 0; k--) begin
            idx = ptr + route_idx_t'(k);
            if (mask[idx]) begin
                pick.found = 1'b1;
                pick.idx   = idx;
            end else begin
                pick = pick;
            end
        end
        return pick;
    endfunction

    function automatic route_mask_t route_onehot(input route_idx_t idx);
        return route_mask_t'(1'b1) << idx;
    endfunction

endpackage

// File: rtl/route_release_timer.sv
// ---------------------------------------------------------------------------
// route_release_timer
// Approach-locking hold timer for one route. Loading starts a countdown of
// RELEASE_CYCLES; done is high in the last held cycle so the owner clears its
// reservation on the edge where the count reaches zero.
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   load : start (or restart) the countdown
//   done : last cycle of the hold period
// ---------------------------------------------------------------------------
module route_release_timer #(
    parameter int RELEASE_CYCLES = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic done
);

    logic [7:0] cnt_r;

    // Countdown register: load, then decrement to zero and stop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= 8'd0;
        end else if (load) begin
            cnt_r <= 8'(RELEASE_CYCLES);
        end else if (cnt_r != 8'd0) begin
            cnt_r <= cnt_r - 8'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign done = (cnt_r == 8'd1);

endmodule

// File: rtl/route_grant_sequencer.sv
// ---------------------------------------------------------------------------
// route_grant_sequencer
// Grants interlocked routes one at a time. A round-robin pick of a requested,
// unreserved route is checked against held conflicting routes and track
// occupancy; a clean route is reserved, locked for LOCK_CYCLES and granted.
// A cancelled grant keeps its reservation for RELEASE_CYCLES (per-route
// timers, running in parallel with the FSM).
//   i_clk       : clock, rising edge
//   i_rst       : asynchronous active-high reset
//   i_req       : per-route request level (bit0 = A ... bit7 = H)
//   i_cancel    : per-route single-cycle release request for a granted route
//   i_occupied  : per-route track occupied; occupied routes are never granted
//   o_grant     : route set and locked
//   o_held      : route reserved (locking, granted or releasing)
//   o_reject    : one-cycle pulse when an evaluated request is refused
//   o_reject_id : refused route index, valid with o_reject
//   o_busy      : FSM not idle
// ---------------------------------------------------------------------------
module route_grant_sequencer
    import route_pkg::*;
#(
    parameter int LOCK_CYCLES    = 4,
    parameter int RELEASE_CYCLES = 8
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_req,
    input  logic [7:0] i_cancel,
    input  logic [7:0] i_occupied,
    output logic [7:0] o_grant,
    output logic [7:0] o_held,
    output logic       o_reject,
    output logic [2:0] o_reject_id,
    output logic       o_busy
);

    localparam logic [7:0] LOCK_LAST = 8'(LOCK_CYCLES - 1);

    seq_state_t  state_r, state_next_s;
    route_idx_t  cand_r, cand_next_s;
    route_idx_t  ptr_r, ptr_next_s;
    logic [7:0]  lock_cnt_r, lock_cnt_next_s;
    route_mask_t held_r, held_next_s;
    route_mask_t grant_r, grant_next_s;
    logic        reject_r, reject_next_s;
    route_idx_t  reject_id_r, reject_id_next_s;

    route_mask_t held_set_s;
    route_mask_t held_clr_s;
    route_mask_t grant_set_s;
    route_mask_t cancel_hit_s;
    route_mask_t release_done_s;
    route_pick_t pick_s;
    logic        refuse_s;
    logic        abort_s;

    // Cancels only count against routes that are actually granted.
    assign cancel_hit_s = i_cancel & grant_r;

    genvar r;
    generate
        for (r = 0; r < NUM_ROUTES; r++) begin : g_release
            route_release_timer #(
                .RELEASE_CYCLES(RELEASE_CYCLES)
            ) u_timer (
                .clk  (i_clk),
                .rst  (i_rst),
                .load (cancel_hit_s[r]),
                .done (release_done_s[r])
            );
        end
    endgenerate

    // Candidate search and CHECK/LOCK conditions. CHECK reads held_r, so a
    // release finishing in the same cycle still blocks a conflicting route.
    always_comb begin
        pick_s   = rr_pick(i_req & ~held_r, ptr_r);
        refuse_s = ((ROUTE_CONFLICT[cand_r] & held_r) != 8'd0) || i_occupied[cand_r];
        abort_s  = !i_req[cand_r] || i_occupied[cand_r];
    end

    // Next-state and per-transition actions of the central FSM.
    always_comb begin
        state_next_s     = state_r;
        cand_next_s      = cand_r;
        ptr_next_s       = ptr_r;
        lock_cnt_next_s  = lock_cnt_r;
        held_set_s       = 8'd0;
        held_clr_s       = 8'd0;
        grant_set_s      = 8'd0;
        reject_next_s    = 1'b0;
        reject_id_next_s = 3'd0;
        case (state_r)
            ST_IDLE: begin
                if (pick_s.found) begin
                    cand_next_s  = pick_s.idx;
                    state_next_s = ST_CHECK;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_CHECK: begin
                if (refuse_s) begin
                    reject_next_s    = 1'b1;
                    reject_id_next_s = cand_r;
                    ptr_next_s       = cand_r + 3'd1;
                    state_next_s     = ST_IDLE;
                end else begin
                    held_set_s      = route_onehot(cand_r);
                    lock_cnt_next_s = 8'd0;
                    state_next_s    = ST_LOCK;
                end
            end
            ST_LOCK: begin
                if (abort_s) begin
                    held_clr_s   = route_onehot(cand_r);
                    state_next_s = ST_IDLE;
                end else if (lock_cnt_r == LOCK_LAST) begin
                    grant_set_s  = route_onehot(cand_r);
                    ptr_next_s   = cand_r + 3'd1;
                    state_next_s = ST_IDLE;
                end else begin
                    lock_cnt_next_s = lock_cnt_r + 8'd1;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Reservation and grant vectors combine FSM actions, cancels and timers.
    always_comb begin
        grant_next_s = (grant_r & ~cancel_hit_s) | grant_set_s;
        held_next_s  = (held_r | held_set_s) & ~held_clr_s & ~release_done_s;
    end

    // State and output registers; reset drops all reservations at once.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r     <= ST_IDLE;
            cand_r      <= 3'd0;
            ptr_r       <= 3'd0;
            lock_cnt_r  <= 8'd0;
            held_r      <= 8'd0;
            grant_r     <= 8'd0;
            reject_r    <= 1'b0;
            reject_id_r <= 3'd0;
        end else begin
            state_r     <= state_next_s;
            cand_r      <= cand_next_s;
            ptr_r       <= ptr_next_s;
            lock_cnt_r  <= lock_cnt_next_s;
            held_r      <= held_next_s;
            grant_r     <= grant_next_s;
            reject_r    <= reject_next_s;
            reject_id_r <= reject_id_next_s;
        end
    end

    assign o_grant     = grant_r;
    assign o_held      = held_r;
    assign o_reject    = reject_r;
    assign o_reject_id = reject_id_r;
    assign o_busy      = (state_r != ST_IDLE);

endmodule

// File: tb/tb_route_grant_sequencer.sv
// ---------------------------------------------------------------------------
// tb_route_grant_sequencer
// Directed scenarios with hand-computed expectations for the route grant
// sequencer (LOCK_CYCLES=4, RELEASE_CYCLES=8), plus a random run checking
// that no two conflicting routes are ever held together.
// ---------------------------------------------------------------------------
module tb_route_grant_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = 8'd0;
    logic [7:0] cancel = 8'd0;
    logic [7:0] occ = 8'd0;
    logic [7:0] grant;
    logic [7:0] held;
    logic       reject;
    logic [2:0] reject_id;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    route_grant_sequencer #(
        .LOCK_CYCLES(4),
        .RELEASE_CYCLES(8)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req       (req),
        .i_cancel    (cancel),
        .i_occupied  (occ),
        .o_grant     (grant),
        .o_held      (held),
        .o_reject    (reject),
        .o_reject_id (reject_id),
        .o_busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 8'd0;
        cancel = 8'd0;
        occ = 8'd0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 8'hFF;
        tick();
        n_checks++;
        if (grant !== 8'd0) begin n_fail++; $display("FAIL reset_grant: got %h expected 00", grant); end
        n_checks++;
        if (held !== 8'd0) begin n_fail++; $display("FAIL reset_held: got %h expected 00", held); end
        n_checks++;
        if (reject !== 1'b0 || reject_id !== 3'd0) begin
            n_fail++; $display("FAIL reset_reject: got %b/%0d expected 0/0", reject, reject_id);
        end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        req = 8'd0;
    endtask

    // Request A from a fresh reset: held from cycle 2, grant at cycle 6.
    task automatic test_latency();
        logic [7:0] exp_grant;
        logic [7:0] exp_held;
        do_reset();
        req = 8'h01;
        for (int k = 1; k <= 6; k++) begin
            tick();
            exp_grant = (k == 6) ? 8'h01 : 8'h00;
            exp_held  = (k >= 2) ? 8'h01 : 8'h00;
            n_checks++;
            if (grant !== exp_grant) begin
                n_fail++; $display("FAIL latency_grant cycle %0d: got %h expected %h", k, grant, exp_grant);
            end
            n_checks++;
            if (held !== exp_held) begin
                n_fail++; $display("FAIL latency_held cycle %0d: got %h expected %h", k, held, exp_held);
            end
        end
    endtask

    // A granted: B conflicts and is refused; C is compatible and granted.
    task automatic test_conflict_reject();
        test_latency();
        req = 8'h03;
        tick();
        n_checks++;
        if (reject !== 1'b0) begin n_fail++; $display("FAIL conflict_early_reject: got %b expected 0", reject); end
        tick();
        n_checks++;
        if (reject !== 1'b1 || reject_id !== 3'd1) begin
            n_fail++; $display("FAIL conflict_reject: got %b/%0d expected 1/1", reject, reject_id);
        end
        n_checks++;
        if (grant !== 8'h01) begin n_fail++; $display("FAIL conflict_grant_kept: got %h expected 01", grant); end
        req = 8'h05;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k == 1) begin
                n_checks++;
                if (reject !== 1'b0) begin n_fail++; $display("FAIL reject_one_cycle: got %b expected 0", reject); end
            end
            if (k >= 5) begin
                n_checks++;
                if (grant !== ((k == 6) ? 8'h05 : 8'h01)) begin
                    n_fail++; $display("FAIL compat_grant cycle %0d: got %h expected %h", k, grant,
                                       (k == 6) ? 8'h05 : 8'h01);
                end
            end
        end
    endtask

    // Cancel A while B waits: A held 8 more cycles, B granted 6 cycles later.
    // A second cancel on the releasing route must be ignored.
    task automatic test_cancel_release();
        logic [7:0] exp_grant;
        logic [7:0] exp_held;
        test_latency();
        req = 8'h02;
        cancel = 8'h01;
        for (int m = 1; m <= 14; m++) begin
            tick();
            cancel = (m == 2) ? 8'h01 : 8'h00;
            exp_grant = (m == 14) ? 8'h02 : 8'h00;
            exp_held  = ((m <= 8) ? 8'h01 : 8'h00) | ((m >= 10) ? 8'h02 : 8'h00);
            n_checks++;
            if (grant !== exp_grant) begin
                n_fail++; $display("FAIL release_grant cycle %0d: got %h expected %h", m, grant, exp_grant);
            end
            n_checks++;
            if (held !== exp_held) begin
                n_fail++; $display("FAIL release_held cycle %0d: got %h expected %h", m, held, exp_held);
            end
        end
        req = 8'h00;
        tick();
        tick();
        n_checks++;
        if (grant !== 8'h02) begin n_fail++; $display("FAIL grant_sticky: got %h expected 02", grant); end
    endtask

    // A and E requested together: A wins, E refused with id 4.
    task automatic test_simultaneous();
        do_reset();
        req = 8'h11;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 6) begin
                n_checks++;
                if (grant !== 8'h01) begin n_fail++; $display("FAIL simul_grant: got %h expected 01", grant); end
            end
        end
        n_checks++;
        if (reject !== 1'b1 || reject_id !== 3'd4) begin
            n_fail++; $display("FAIL simul_reject: got %b/%0d expected 1/4", reject, reject_id);
        end
        n_checks++;
        if (grant !== 8'h01) begin n_fail++; $display("FAIL simul_grant_kept: got %h expected 01", grant); end
    endtask

    // D's track becomes occupied during LOCK: silent abort, nothing granted.
    task automatic test_occupied_abort();
        do_reset();
        req = 8'h08;
        tick();
        tick();
        n_checks++;
        if (held !== 8'h08) begin n_fail++; $display("FAIL abort_lock_held: got %h expected 08", held); end
        tick();
        occ = 8'h08;
        tick();
        n_checks++;
        if (held !== 8'h00 || grant !== 8'h00) begin
            n_fail++; $display("FAIL abort_cleared: got held %h grant %h expected 00 00", held, grant);
        end
        n_checks++;
        if (reject !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL abort_flags: got reject %b busy %b expected 0 0", reject, busy);
        end
        tick();
        n_checks++;
        if (reject !== 1'b0) begin n_fail++; $display("FAIL abort_no_reject: got %b expected 0", reject); end
        req = 8'h00;
        occ = 8'h00;
    endtask

    // Both A and C releasing, then reset asserted between edges.
    task automatic test_async_reset();
        do_reset();
        req = 8'h05;
        for (int k = 1; k <= 12; k++) tick();
        n_checks++;
        if (grant !== 8'h05) begin n_fail++; $display("FAIL ar_grant: got %h expected 05", grant); end
        cancel = 8'h05;
        tick();
        cancel = 8'h00;
        n_checks++;
        if (held !== 8'h05 || grant !== 8'h00) begin
            n_fail++; $display("FAIL ar_releasing: got held %h grant %h expected 05 00", held, grant);
        end
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (held !== 8'h00 || grant !== 8'h00 || busy !== 1'b0 || reject !== 1'b0) begin
            n_fail++; $display("FAIL ar_async_clear: got held %h grant %h busy %b reject %b expected all 0",
                               held, grant, busy, reject);
        end
        req = 8'h00;
        tick();
        rst = 1'b0;
    endtask

    // Random traffic: no held route may share the set with a conflicting one,
    // and every granted route must be held.
    task automatic test_random_invariant();
        logic [7:0] row;
        logic       viol;
        do_reset();
        for (int c = 0; c < 10000; c++) begin
            if (c % 16 == 0) req = 8'($urandom);
            if (c % 32 == 0) occ = 8'($urandom) & 8'($urandom) & 8'($urandom);
            cancel = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h00;
            tick();
            viol = 1'b0;
            for (int i = 0; i < 8; i++) begin
                row = 8'd0;
                row[(i + 1) % 8] = 1'b1;
                row[(i + 7) % 8] = 1'b1;
                row[(i + 4) % 8] = 1'b1;
                if (held[i] && ((held & row) != 8'd0)) viol = 1'b1;
            end
            n_checks++;
            if (viol !== 1'b0) begin
                n_fail++; $display("FAIL conflict_invariant cycle %0d: got held %h expected no conflicting pair", c, held);
            end
            n_checks++;
            if ((grant & ~held) !== 8'd0) begin
                n_fail++; $display("FAIL grant_subset cycle %0d: got grant %h held %h expected grant within held",
                                   c, grant, held);
            end
        end
        cancel = 8'h00;
    endtask

    initial begin
        test_reset();
        test_latency();
        test_conflict_reject();
        test_cancel_release();
        test_simultaneous();
        test_occupied_abort();
        test_async_reset();
        test_random_invariant();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
